// File: rtl/jtkicker_objdraw.sv
// Sprite row renderer: fetches two 32-bit ROM words per 16-pixel sprite row and
// paints them into a ping-pong pair of 256x8 line buffers that are read out and erased on display.
`default_nettype none

module jtkicker_objdraw #(
  parameter logic [7:0] HOFFSET = 8'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pxl_cen,
  input  logic        hs,
  input  logic        LHBL,
  input  logic [8:0]  hdump,
  input  logic        flip,
  input  logic        draw,
  input  logic [7:0]  obj_code,
  input  logic [7:0]  obj_x,
  input  logic [3:0]  obj_ysub,
  input  logic        obj_hflip,
  input  logic        obj_vflip,
  input  logic [3:0]  obj_pal,
  output logic        busy,
  output logic [12:0] rom_addr,
  output logic        rom_cs,
  input  logic [31:0] rom_data,
  input  logic        rom_ok,
  output logic [7:0]  pxl
);

  typedef enum logic [2:0] {IDLE, REQ0, WR0, REQ1, WR1} state_t;

  state_t      st;
  logic        line;
  logic        addr_new;
  logic [7:0]  code_l;
  logic [7:0]  x_l;
  logic [3:0]  ysub_l;
  logic [3:0]  pal_l;
  logic        hflip_l;
  logic        vflip_l;
  logic [31:0] data_l;
  logic [2:0]  cnt;

  // Both line buffers share one array; the MSB of the index selects the buffer.
  logic [7:0]  ram [0:511];

  logic [2:0]  nib_idx;
  logic [3:0]  pix;
  logic [7:0]  wx;
  logic [7:0]  waddr;
  logic        we;
  logic        erase;
  logic        unused_hdump;

  assign unused_hdump = hdump[8];

  always_comb begin
    nib_idx = hflip_l ? ~cnt : cnt;
    pix     = data_l[{nib_idx, 2'b00} +: 4];
    wx      = x_l + HOFFSET + {4'd0, st == WR1, cnt};
    waddr   = flip ? ~wx : wx;
    we      = (st == WR0 || st == WR1) && !hs && (pix != 4'd0);
    erase   = pxl_cen && LHBL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      line     <= 1'b0;
      addr_new <= 1'b0;
      busy     <= 1'b0;
      rom_cs   <= 1'b0;
      rom_addr <= 13'd0;
      code_l   <= 8'd0;
      x_l      <= 8'd0;
      ysub_l   <= 4'd0;
      pal_l    <= 4'd0;
      hflip_l  <= 1'b0;
      vflip_l  <= 1'b0;
      data_l   <= 32'd0;
      cnt      <= 3'd0;
      pxl      <= 8'd0;
    end else begin
      if (hs) line <= ~line;

      if (!LHBL) pxl <= 8'd0;
      else if (pxl_cen) pxl <= ram[{~line, hdump[7:0]}];

      if (hs && st != IDLE) begin
        // A new line has started: drop whatever is left of this sprite.
        st       <= IDLE;
        busy     <= 1'b0;
        rom_cs   <= 1'b0;
        addr_new <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            if (draw && !hs) begin
              code_l   <= obj_code;
              x_l      <= obj_x;
              ysub_l   <= obj_ysub;
              pal_l    <= obj_pal;
              hflip_l  <= obj_hflip;
              vflip_l  <= obj_vflip;
              rom_addr <= {obj_code, obj_vflip ? ~obj_ysub : obj_ysub, obj_hflip};
              rom_cs   <= 1'b1;
              addr_new <= 1'b1;
              busy     <= 1'b1;
              st       <= REQ0;
            end
          end
          REQ0, REQ1: begin
            // rom_ok in the cycle the address changed may still refer to the old word.
            if (addr_new) begin
              addr_new <= 1'b0;
            end else if (rom_ok) begin
              data_l <= rom_data;
              rom_cs <= 1'b0;
              cnt    <= 3'd0;
              st     <= (st == REQ0) ? WR0 : WR1;
            end
          end
          WR0: begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              rom_addr <= {code_l, vflip_l ? ~ysub_l : ysub_l, ~hflip_l};
              rom_cs   <= 1'b1;
              addr_new <= 1'b1;
              st       <= REQ1;
            end
          end
          WR1: begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              busy <= 1'b0;
              st   <= IDLE;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  // Write and erase always target different buffers, so they never collide.
  always_ff @(posedge clk) begin
    if (we) ram[{line, waddr}] <= {pal_l, pix};
    if (erase) ram[{~line, hdump[7:0]}] <= 8'd0;
  end

endmodule

`default_nettype wire
